phase_freq_detector: RTL and testbench
======================================

// Module: phase_freq_detector
// PURPOSE
//  Digital tri-state phase/frequency detector: compares rising edges of reference clock ref_in and
//  DCO-divided feedback fb_in, both sampled in the clk domain, and drives up/down to the PLL loop filter.
//  up = reference leads (speed DCO up); down = feedback leads. Also reports signed pulse width and lock.
// PARAMETERS
//  SYNC_STAGES     2      synchroniser depth on ref_in and fb_in (>=2)
//  LOCK_WINDOW     4      max |pulse width| in clk cycles for a comparison to count as in-phase
//  LOCK_COUNT      64     consecutive in-phase comparisons needed to assert locked
//  TIMEOUT_CYCLES  4096   pulse timeout; used only when PFD_TIMEOUT_EN is defined
// PORTS
//  clk        in   1   system clock (100 MHz)
//  rst_n      in   1   asynchronous active-low reset
//  ref_in     in   1   reference clock, asynchronous to clk
//  fb_in      in   1   feedback clock from DCO divider, asynchronous to clk
//  enable     in   1   detector enable
//  up         out  1   reference-leads pulse to loop filter (registered)
//  down       out  1   feedback-leads pulse to loop filter (registered)
//  phase_err  out  16  signed width of last completed pulse; +up, -down
//  locked     out  1   lock indicator
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, up=0, down=0, phase_err=0, locked=0, width and good counters 0.
//  - Input path: SYNC_STAGES-flop synchroniser, then one history flop; ref_rise/fb_rise = 1-cycle pulses.
//    Input sampled high at clk edge N -> FSM reacts at edge N+SYNC_STAGES (up/down change after that edge).
//  - FSM states IDLE, UP, DOWN; up=(state==UP), down=(state==DOWN); never both high.
//    IDLE: ref_rise&!fb_rise -> UP, width=1; fb_rise&!ref_rise -> DOWN, width=1;
//          both -> stay IDLE, completed comparison with width 0 (phase_err=0).
//    UP:   !fb_rise -> stay, width+1 (saturate 32767); ref_rise&!fb_rise in UP = cycle slip (stay UP).
//          fb_rise&!ref_rise -> IDLE, phase_err=+width; fb_rise&ref_rise -> phase_err=+width, stay UP, width=1.
//    DOWN: mirror of UP with roles of ref/fb swapped, phase_err=-width.
//  - phase_err updates on the same edge the pulse ends; holds otherwise. width = cycles up/down was high.
//  - Lock detector, evaluated per completed comparison: |width|<=LOCK_WINDOW -> good_cnt+1 (saturate at
//    LOCK_COUNT), else good_cnt=0. locked=1 once good_cnt==LOCK_COUNT (same edge as the completing compare).
//    Any cycle slip or out-of-window compare -> good_cnt=0, locked=0 on that edge.
//  - enable=0: next edge forces IDLE, up=down=0, width=0, good_cnt=0, locked=0; phase_err holds;
//    synchroniser keeps running so no stale edge fires on re-enable.
//  - enable 0->1: first edge detected after re-enable starts a fresh comparison.
// CONFIGURATION
//  PFD_TIMEOUT_EN defined: in UP/DOWN, when width reaches TIMEOUT_CYCLES with no closing edge -> IDLE,
//    phase_err = +32767 (UP) / -32767 (DOWN), good_cnt=0, locked=0 (lost-feedback recovery).
//  Not defined: UP/DOWN persist indefinitely; width saturates at 32767; no forced exit.
// TESTING
//  1 Reset: assert rst_n=0 mid-UP pulse -> up=down=0, phase_err=0, locked=0 immediately (async).
//  2 ref high at edge N, fb high at edge N+5 -> up=1 after edge N+2, up=0 after edge N+7, phase_err=+5.
//  3 fb high at N, ref high at N+3 -> down high for 3 cycles, phase_err=-3 (0xFFFD), up stays 0.
//  4 ref/fb same freq, fb lagging 2 cycles for 64 periods -> locked=1 on 64th compare; one compare at 10
//    cycles -> locked=0 same edge.
//  5 ref at 2x fb freq -> cycle slip: up held high across two ref edges, locked=0; simultaneous ref/fb
//    edges -> phase_err=0, up/down stay 0.
//  6 PFD_TIMEOUT_EN, TIMEOUT_CYCLES=16, fb held 0 -> up high 16 cycles then 0, phase_err=+32767;
//    without macro -> up remains 1 past 40000 cycles, internal width=32767.

Source files
------------

// File: rtl/phase_freq_detector.sv
// Tri-state digital phase/frequency detector with signed pulse-width report and lock detection.
// Define PFD_TIMEOUT_EN to force UP/DOWN back to IDLE after TIMEOUT_CYCLES with no closing edge.
module phase_freq_detector #(
   parameter int SYNC_STAGES    = 2,
   parameter int LOCK_WINDOW    = 4,
   parameter int LOCK_COUNT     = 64,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ref_in,
   input  logic               fb_in,
   input  logic               enable,
   output logic               up,
   output logic               down,
   output logic signed [15:0] phase_err,
   output logic               locked
);

   localparam logic [15:0] WIDTH_MAX = 16'd32767;
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COUNT);

   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

   logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
   logic                   ref_d, fb_d;
   logic                   ref_rise, fb_rise;

   state_t               state, state_next;
   logic [15:0]          width, width_next, width_inc;
   logic signed [15:0]   phase_err_next;
   logic [GW-1:0]        good_cnt, good_next;
   logic                 locked_next;
   logic                 compare, slip, timeout;
   logic [15:0]          cmp_width;

   // Synchronisers and history flops keep running while disabled so no stale edge fires later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_sync <= '0;
         fb_sync  <= '0;
         ref_d    <= 1'b0;
         fb_d     <= 1'b0;
      end else begin
         ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
         fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
         ref_d    <= ref_sync[SYNC_STAGES-1];
         fb_d     <= fb_sync[SYNC_STAGES-1];
      end
   end

   assign ref_rise  = ref_sync[SYNC_STAGES-1] & ~ref_d;
   assign fb_rise   = fb_sync[SYNC_STAGES-1] & ~fb_d;
   assign width_inc = (width == WIDTH_MAX) ? width : width + 16'd1;

`ifdef PFD_TIMEOUT_EN
   assign timeout = (width >= 16'(TIMEOUT_CYCLES));
`else
   // Without the recovery feature the pulse persists; width simply saturates.
   logic timeout_unused;
   assign timeout_unused = (width >= 16'(TIMEOUT_CYCLES));
   assign timeout        = 1'b0;
`endif

   always_comb begin
      state_next     = state;
      width_next     = width;
      phase_err_next = phase_err;
      compare        = 1'b0;
      cmp_width      = 16'd0;
      slip           = 1'b0;
      if (enable) begin
         unique case (state)
            IDLE: begin
               if (ref_rise && fb_rise) begin
                  compare        = 1'b1;
                  phase_err_next = 16'sd0;
               end else if (ref_rise) begin
                  state_next = UP;
                  width_next = 16'd1;
               end else if (fb_rise) begin
                  state_next = DOWN;
                  width_next = 16'd1;
               end
            end
            UP: begin
               if (fb_rise) begin
                  compare        = 1'b1;
                  cmp_width      = width;
                  phase_err_next = width;
                  state_next     = ref_rise ? UP : IDLE;
                  width_next     = ref_rise ? 16'd1 : 16'd0;
               end else if (timeout) begin
                  slip           = 1'b1;
                  state_next     = IDLE;
                  width_next     = 16'd0;
                  phase_err_next = 16'sd32767;
               end else begin
                  width_next = width_inc;
                  slip       = ref_rise;
               end
            end
            DOWN: begin
               if (ref_rise) begin
                  compare        = 1'b1;
                  cmp_width      = width;
                  phase_err_next = -width;
                  state_next     = fb_rise ? DOWN : IDLE;
                  width_next     = fb_rise ? 16'd1 : 16'd0;
               end else if (timeout) begin
                  slip           = 1'b1;
                  state_next     = IDLE;
                  width_next     = 16'd0;
                  phase_err_next = -16'sd32767;
               end else begin
                  width_next = width_inc;
                  slip       = fb_rise;
               end
            end
            default: state_next = IDLE;
         endcase
      end else begin
         state_next = IDLE;
         width_next = 16'd0;
      end
   end

   // Lock bookkeeping: each completed comparison either extends the in-phase run or breaks it.
   always_comb begin
      good_next = good_cnt;
      if (!enable || slip) begin
         good_next = '0;
      end else if (compare) begin
         if (cmp_width <= 16'(LOCK_WINDOW))
            good_next = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
         else
            good_next = '0;
      end
      locked_next = (good_next == GOOD_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         width     <= 16'd0;
         phase_err <= 16'sd0;
         good_cnt  <= '0;
         locked    <= 1'b0;
         up        <= 1'b0;
         down      <= 1'b0;
      end else begin
         state     <= state_next;
         width     <= width_next;
         phase_err <= phase_err_next;
         good_cnt  <= good_next;
         locked    <= locked_next;
         up        <= (state_next == UP);
         down      <= (state_next == DOWN);
      end
   end

endmodule

// File: tb/tb_phase_freq_detector.sv
// Directed testbench for phase_freq_detector: lead/lag pulses, back-to-back compares, enable,
// async reset, lock/unlock, cycle slip and long unclosed pulses.
module tb_phase_freq_detector;

   logic               clk    = 1'b0;
   logic               rst_n  = 1'b0;
   logic               ref_in = 1'b0;
   logic               fb_in  = 1'b0;
   logic               enable = 1'b1;
   logic               up, down, locked;
   logic signed [15:0] phase_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   phase_freq_detector #(
      .SYNC_STAGES(2), .LOCK_WINDOW(4), .LOCK_COUNT(64), .TIMEOUT_CYCLES(4096)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .fb_in(fb_in), .enable(enable),
      .up(up), .down(down), .phase_err(phase_err), .locked(locked)
   );

   // One clock edge; observation happens 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap(input int n);
      ref_in = 1'b0;
      fb_in  = 1'b0;
      repeat (n) tick();
   endtask

   // Ref rises at local edge 0, fb rises at local edge lag; compare completes at edge lag+2.
   task automatic run_period(input int lag);
      for (int i = 0; i < lag + 8; i++) begin
         ref_in = (i < 4);
         fb_in  = (i >= lag) && (i < lag + 4);
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      total++;
      if ({up, down} !== 2'b00) begin
         bad++; $display("[TB] FAIL reset_updown: got %b expected 00", {up, down});
      end
      total++;
      if (phase_err !== 16'sd0 || locked !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_err_lock: got %0d/%b expected 0/0", phase_err, locked);
      end
      rst_n = 1'b1;
      idle_gap(4);
   endtask

   task automatic test_ref_leads();
      for (int i = 0; i < 8; i++) begin
         ref_in = (i < 4);
         fb_in  = (i >= 5);
         tick();
         if (i == 1) begin
            total++;
            if (up !== 1'b0) begin bad++; $display("[TB] FAIL lead_latency: got %b expected 0", up); end
         end
         if (i == 2) begin
            total++;
            if ({up, down} !== 2'b10) begin bad++; $display("[TB] FAIL lead_up_on: got %b expected 10", {up, down}); end
         end
         if (i == 6) begin
            total++;
            if (up !== 1'b1) begin bad++; $display("[TB] FAIL lead_up_hold: got %b expected 1", up); end
         end
         if (i == 7) begin
            total++;
            if (up !== 1'b0 || phase_err !== 16'sd5) begin
               bad++; $display("[TB] FAIL lead_end: got up=%b err=%0d expected up=0 err=5", up, phase_err);
            end
         end
      end
      idle_gap(4);
   endtask

   task automatic test_fb_leads();
      for (int i = 0; i < 6; i++) begin
         fb_in  = (i < 4);
         ref_in = (i >= 3);
         tick();
         if (i == 2) begin
            total++;
            if ({up, down} !== 2'b01) begin bad++; $display("[TB] FAIL lag_down_on: got %b expected 01", {up, down}); end
         end
         if (i == 5) begin
            total++;
            if ({up, down} !== 2'b00 || phase_err !== 16'hFFFD) begin
               bad++; $display("[TB] FAIL lag_end: got %b err=%h expected 00 err=fffd", {up, down}, phase_err);
            end
         end
      end
      idle_gap(4);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 13; i++) begin
         ref_in = (i < 3) || (i >= 5);
         fb_in  = (i == 5) || (i == 6) || (i >= 9);
         tick();
         if (i == 7) begin
            total++;
            if (up !== 1'b1 || phase_err !== 16'sd5) begin
               bad++; $display("[TB] FAIL b2b_first: got up=%b err=%0d expected up=1 err=5", up, phase_err);
            end
         end
         if (i == 11) begin
            total++;
            if (up !== 1'b0 || phase_err !== 16'sd4) begin
               bad++; $display("[TB] FAIL b2b_second: got up=%b err=%0d expected up=0 err=4", up, phase_err);
            end
         end
      end
      idle_gap(4);
   endtask

   // phase_err still holds 4 from the back-to-back scenario.
   task automatic test_enable();
      for (int i = 0; i < 9; i++) begin
         ref_in = (i < 3);
         fb_in  = (i >= 4) && (i < 7);
         enable = !((i >= 3) && (i <= 6));
         tick();
         if (i == 2) begin
            total++;
            if (up !== 1'b1) begin bad++; $display("[TB] FAIL en_up_on: got %b expected 1", up); end
         end
         if (i == 3) begin
            total++;
            if (up !== 1'b0 || phase_err !== 16'sd4) begin
               bad++; $display("[TB] FAIL en_force_idle: got up=%b err=%0d expected up=0 err=4", up, phase_err);
            end
         end
         if (i == 7 || i == 8) begin
            total++;
            if ({up, down} !== 2'b00) begin bad++; $display("[TB] FAIL en_no_stale: got %b expected 00", {up, down}); end
         end
      end
      enable = 1'b1;
      idle_gap(4);
   endtask

   task automatic test_async_reset();
      ref_in = 1'b1;
      repeat (3) tick();
      total++;
      if (up !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre: got %b expected 1", up); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({up, down} !== 2'b00 || phase_err !== 16'sd0 || locked !== 1'b0) begin
         bad++; $display("[TB] FAIL areset_now: got %b err=%0d lock=%b expected 00 0 0", {up, down}, phase_err, locked);
      end
      ref_in = 1'b0;
      tick();
      rst_n = 1'b1;
      idle_gap(4);
   endtask

   task automatic test_lock();
      enable = 1'b0;
      tick();
      enable = 1'b1;
      idle_gap(4);
      repeat (63) run_period(2);
      total++;
      if (locked !== 1'b0) begin bad++; $display("[TB] FAIL lock_63: got %b expected 0", locked); end
      for (int i = 0; i < 10; i++) begin
         ref_in = (i < 4);
         fb_in  = (i >= 2) && (i < 6);
         tick();
         if (i == 3) begin
            total++;
            if (locked !== 1'b0) begin bad++; $display("[TB] FAIL lock_pre64: got %b expected 0", locked); end
         end
         if (i == 4) begin
            total++;
            if (locked !== 1'b1 || phase_err !== 16'sd2) begin
               bad++; $display("[TB] FAIL lock_64: got lock=%b err=%0d expected 1 2", locked, phase_err);
            end
         end
      end
      for (int i = 0; i < 18; i++) begin
         ref_in = (i < 4);
         fb_in  = (i >= 10) && (i < 14);
         tick();
         if (i == 11) begin
            total++;
            if (locked !== 1'b1) begin bad++; $display("[TB] FAIL unlock_pre: got %b expected 1", locked); end
         end
         if (i == 12) begin
            total++;
            if (locked !== 1'b0 || phase_err !== 16'sd10) begin
               bad++; $display("[TB] FAIL unlock_wide: got lock=%b err=%0d expected 0 10", locked, phase_err);
            end
         end
      end
      idle_gap(4);
   endtask

   task automatic test_slip_and_simultaneous();
      repeat (64) run_period(2);
      total++;
      if (locked !== 1'b1) begin bad++; $display("[TB] FAIL slip_prelock: got %b expected 1", locked); end
      for (int i = 0; i < 16; i++) begin
         ref_in = (i < 4) || ((i >= 8) && (i < 12));
         fb_in  = (i >= 12);
         tick();
         if (i == 10) begin
            total++;
            if (up !== 1'b1 || locked !== 1'b0) begin
               bad++; $display("[TB] FAIL slip_edge: got up=%b lock=%b expected 1 0", up, locked);
            end
         end
         if (i == 13) begin
            total++;
            if (up !== 1'b1) begin bad++; $display("[TB] FAIL slip_hold: got %b expected 1", up); end
         end
         if (i == 14) begin
            total++;
            if (up !== 1'b0 || phase_err !== 16'sd12) begin
               bad++; $display("[TB] FAIL slip_end: got up=%b err=%0d expected 0 12", up, phase_err);
            end
         end
      end
      idle_gap(4);
      for (int i = 0; i < 5; i++) begin
         ref_in = 1'b1;
         fb_in  = 1'b1;
         tick();
         total++;
         if ({up, down} !== 2'b00) begin bad++; $display("[TB] FAIL simul_updown: got %b expected 00", {up, down}); end
         if (i == 2) begin
            total++;
            if (phase_err !== 16'sd0) begin bad++; $display("[TB] FAIL simul_err: got %0d expected 0", phase_err); end
         end
      end
      idle_gap(4);
   endtask

   task automatic test_long_pulse();
      logic exp_up;
`ifdef PFD_TIMEOUT_EN
      exp_up = 1'b0;
`else
      exp_up = 1'b1;
`endif
      ref_in = 1'b1;
      repeat (40000) tick();
      total++;
      if (up !== exp_up) begin bad++; $display("[TB] FAIL long_up: got %b expected %b", up, exp_up); end
      fb_in = 1'b1;
      repeat (3) tick();
      total++;
      if (up !== 1'b0 || phase_err !== 16'sd32767) begin
         bad++; $display("[TB] FAIL long_end: got up=%b err=%0d expected 0 32767", up, phase_err);
      end
      idle_gap(4);
   endtask

   initial begin
      test_reset();
      test_ref_leads();
      test_fb_leads();
      test_back_to_back();
      test_enable();
      test_async_reset();
      test_lock();
      test_slip_and_simultaneous();
      test_long_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
